// File: rtl/sync_gray_ptr_multi.sv
// Destination-domain synchronizer for async FIFO gray pointers and flags.
// Adds registered binary decode, advance delta, flag edges and gray check.
module sync_gray_ptr_multi #(
    parameter int AWIDTH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int NFLAGS      = 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [AWIDTH:0]   ptr_gray_async_i,
    input  logic [NFLAGS-1:0] flags_async_i,
    output logic [AWIDTH:0]   ptr_gray_o,
    output logic [AWIDTH:0]   ptr_bin_o,
    output logic [AWIDTH:0]   ptr_delta_o,
    output logic              ptr_chg_o,
    output logic [NFLAGS-1:0] flags_o,
    output logic [NFLAGS-1:0] flags_rise_o,
    output logic [NFLAGS-1:0] flags_fall_o,
    output logic              gray_err_o
);

    localparam int PW = AWIDTH + 1;

    logic [PW-1:0]     ptr_sync [SYNC_STAGES];
    logic [NFLAGS-1:0] flg_sync [SYNC_STAGES];

    logic [PW-1:0]     gray_prev;
    logic [NFLAGS-1:0] flags_prev;

    logic [PW-1:0]     bin_d;
    logic [PW-1:0]     delta_d;
    logic [PW-1:0]     gray_diff;
    logic              multi_bit;

    assign ptr_gray_o = ptr_sync[SYNC_STAGES-1];
    assign flags_o    = flg_sync[SYNC_STAGES-1];

    // Multi-flop synchronizer chains for the pointer and the flags
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ptr_sync[i] <= '0;
                flg_sync[i] <= '0;
            end
        end else begin
            ptr_sync[0] <= ptr_gray_async_i;
            flg_sync[0] <= flags_async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ptr_sync[i] <= ptr_sync[i-1];
                flg_sync[i] <= flg_sync[i-1];
            end
        end
    end

    // Gray-to-binary decode, modular advance and multi-bit change detect
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < PW; i++) begin
            bin_d[i] = ^(ptr_gray_o >> i);
        end
        delta_d   = bin_d - ptr_bin_o;
        gray_diff = ptr_gray_o ^ gray_prev;
        multi_bit = |(gray_diff & (gray_diff - PW'(1)));
    end

    // Registered decode stage; ptr_bin_o doubles as the previous sample
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ptr_bin_o   <= '0;
            ptr_delta_o <= '0;
            ptr_chg_o   <= 1'b0;
        end else begin
            ptr_bin_o   <= bin_d;
            ptr_delta_o <= delta_d;
            ptr_chg_o   <= (delta_d != '0);
        end
    end

    // Per-flag edge strobes, aligned with the decode stage
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            flags_prev   <= '0;
            flags_rise_o <= '0;
            flags_fall_o <= '0;
        end else begin
            flags_prev   <= flags_o;
            flags_rise_o <= flags_o & ~flags_prev;
            flags_fall_o <= ~flags_o & flags_prev;
        end
    end

    // Sticky coherency error when successive gray samples differ in >1 bit
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            gray_prev  <= '0;
            gray_err_o <= 1'b0;
        end else begin
            gray_prev  <= ptr_gray_o;
            gray_err_o <= gray_err_o | multi_bit;
        end
    end

endmodule

// File: tb/tb_sync_gray_ptr_multi.sv
// Directed bench for sync_gray_ptr_multi (AWIDTH=4, SYNC_STAGES=3, NFLAGS=2).
// Expected output snapshots are queued with a due cycle and checked then.
module tb_sync_gray_ptr_multi;

    logic       clk = 1'b0;
    logic       srst;
    logic [4:0] ptr_in;
    logic [1:0] flg_in;

    logic [4:0] ptr_gray_o;
    logic [4:0] ptr_bin_o;
    logic [4:0] ptr_delta_o;
    logic       ptr_chg_o;
    logic [1:0] flags_o;
    logic [1:0] flags_rise_o;
    logic [1:0] flags_fall_o;
    logic       gray_err_o;

    typedef struct {
        int          due;
        string       tag;
        logic [22:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [22:0] Z = '0;

    sync_gray_ptr_multi #(
        .AWIDTH(4),
        .SYNC_STAGES(3),
        .NFLAGS(2)
    ) dut (
        .clk_i           (clk),
        .srst_i          (srst),
        .ptr_gray_async_i(ptr_in),
        .flags_async_i   (flg_in),
        .ptr_gray_o      (ptr_gray_o),
        .ptr_bin_o       (ptr_bin_o),
        .ptr_delta_o     (ptr_delta_o),
        .ptr_chg_o       (ptr_chg_o),
        .flags_o         (flags_o),
        .flags_rise_o    (flags_rise_o),
        .flags_fall_o    (flags_fall_o),
        .gray_err_o      (gray_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [22:0] ex(
        input logic [4:0] gray,
        input logic [4:0] bin,
        input logic [4:0] delta,
        input logic       chg,
        input logic [1:0] flg,
        input logic [1:0] rise,
        input logic [1:0] fall,
        input logic       err
    );
        return {gray, bin, delta, chg, flg, rise, fall, err};
    endfunction

    task automatic push(input int n, input string tag, input logic [22:0] v);
        exp_t e;
        int   k;
        e.due = cyc + n;
        e.tag = tag;
        e.v   = v;
        k     = q.size();
        while (k > 0 && q[k-1].due > e.due) k--;
        q.insert(k, e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [22:0] obs;
        @(posedge clk);
        cyc++;
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e   = q.pop_front();
            obs = {ptr_gray_o, ptr_bin_o, ptr_delta_o, ptr_chg_o,
                   flags_o, flags_rise_o, flags_fall_o, gray_err_o};
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s cyc=%0d observed=%b expected=%b",
                       e.tag, cyc, obs, e.v);
            end
        end
    endtask

    initial begin
        int          wrap_seq [5];
        int          prev;
        wrap_seq = '{29, 30, 31, 0, 1};

        // reset held 3 cycles with nonzero inputs
        srst   = 1'b1;
        ptr_in = g(7);
        flg_in = 2'b11;
        tick();
        tick();
        push(1, "rst_hold", Z);
        tick();
        srst = 1'b0;
        push(1, "rel_c1", Z);
        push(2, "rel_c2", Z);
        push(3, "rel_sync", ex(g(7), 5'd0, 5'd0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0));
        push(4, "rel_dec", ex(g(7), 5'd7, 5'd7, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0));
        push(5, "rel_settle", ex(g(7), 5'd7, 5'd0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0));
        repeat (6) tick();

        // latency: pointer 0 -> 1
        srst   = 1'b1;
        ptr_in = '0;
        flg_in = '0;
        push(1, "rst2", Z);
        tick();
        srst   = 1'b0;
        ptr_in = g(1);
        push(2, "lat_e2", Z);
        push(3, "lat_e3", ex(g(1), 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        push(4, "lat_e4", ex(g(1), 5'd1, 5'd1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0));
        push(5, "lat_e5", ex(g(1), 5'd1, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        repeat (6) tick();

        // legal single-step advance every cycle up to 28
        for (int b = 2; b <= 28; b++) begin
            ptr_in = g(b);
            tick();
        end
        repeat (5) tick();
        push(1, "walk_settled", ex(g(28), 5'd28, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        tick();

        // wrap-around 29,30,31,0,1 one step per 4 cycles
        prev = 28;
        foreach (wrap_seq[i]) begin
            push(3, $sformatf("wrap_pre_%0d", wrap_seq[i]),
                 ex(g(wrap_seq[i]), 5'(prev), 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
            push(4, $sformatf("wrap_dec_%0d", wrap_seq[i]),
                 ex(g(wrap_seq[i]), 5'(wrap_seq[i]), 5'd1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0));
            ptr_in = g(wrap_seq[i]);
            repeat (4) tick();
            prev = wrap_seq[i];
        end
        repeat (2) tick();

        // flags: both rise, bit1 falls 5 cycles later
        flg_in = 2'b11;
        push(3, "flg_sync", ex(g(1), 5'd1, 5'd0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0));
        push(4, "flg_rise", ex(g(1), 5'd1, 5'd0, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0));
        push(5, "flg_rise_end", ex(g(1), 5'd1, 5'd0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0));
        repeat (5) tick();
        flg_in = 2'b01;
        push(3, "flg_drop_sync", ex(g(1), 5'd1, 5'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0));
        push(4, "flg_fall", ex(g(1), 5'd1, 5'd0, 1'b0, 2'b01, 2'b00, 2'b10, 1'b0));
        push(5, "flg_fall_end", ex(g(1), 5'd1, 5'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0));
        repeat (6) tick();

        // coherency error: 0 -> 00110 jump, then a legal step
        srst   = 1'b1;
        ptr_in = '0;
        flg_in = '0;
        push(1, "rst3", Z);
        tick();
        srst = 1'b0;
        repeat (3) tick();
        ptr_in = 5'b00110;
        push(3, "err_pre", ex(5'b00110, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        push(4, "err_set", ex(5'b00110, 5'd4, 5'd4, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1));
        repeat (5) tick();
        ptr_in = g(5);
        push(3, "err_hold_sync", ex(g(5), 5'd4, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1));
        push(4, "err_hold", ex(g(5), 5'd5, 5'd1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1));
        push(5, "err_hold_settle", ex(g(5), 5'd5, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1));
        repeat (6) tick();
        srst   = 1'b1;
        ptr_in = '0;
        push(1, "err_clr", Z);
        tick();
        srst = 1'b0;
        push(2, "err_clr_after", Z);
        repeat (3) tick();

        // reset while a change is inside the sync chain
        ptr_in = g(15);
        push(1, "mid_c1", Z);
        push(2, "mid_rst", Z);
        push(3, "mid_c3", Z);
        push(4, "mid_c4", Z);
        push(5, "mid_resync", ex(g(15), 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        push(6, "mid_dec", ex(g(15), 5'd15, 5'd15, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0));
        push(7, "mid_settle", ex(g(15), 5'd15, 5'd0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0));
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        repeat (6) tick();

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
